// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and default widths for the instruction-fetch master
package fetch_pkg;
    localparam int PKG_DATA_WIDTH = 32;
    localparam int PKG_ADDR_WIDTH = 10;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    typedef struct packed {
        logic [PKG_ADDR_WIDTH-1:0] addr;
        logic [PKG_DATA_WIDTH-1:0] data;
    } fifo_entry_t;
endpackage

// File: rtl/axi_bus.sv
// AXI_BUS: AXI4-Lite channels between the fetch master and the ROM slave
interface AXI_BUS #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  aw_valid;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic                  w_valid;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  b_ready;
    logic                  ar_valid;
    logic                  ar_ready;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic                  r_valid;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_data;

    modport Master (
        output aw_valid, aw_addr, w_valid, w_data, b_ready, ar_valid, ar_addr, r_ready,
        input  ar_ready, r_valid, r_data
    );

    modport Slave (
        input  aw_valid, aw_addr, w_valid, w_data, b_ready, ar_valid, ar_addr, r_ready,
        output ar_ready, r_valid, r_data
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO; flush beats push, push allowed on full when popping
module fetch_fifo #(
    parameter int WIDTH = 42,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [PW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = count == (PW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // pointer/occupancy update; flush empties the queue regardless of push/pop
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/axi4_lite_fetch_master.sv
// axi4_lite_fetch_master: one-outstanding AXI4-Lite fetch into a prefetch FIFO with redirect; FETCH_PERF_CNT_EN adds perf counters
module axi4_lite_fetch_master
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = PKG_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = PKG_ADDR_WIDTH,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_addr,
    input  logic                  instr_ready,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_stall_cnt,
`endif
    AXI_BUS.Master                amba_master
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t                           state;
    logic [ADDR_WIDTH-1:0]            req_addr;
    logic [ADDR_WIDTH-1:0]            pend_addr;
    logic [ADDR_WIDTH-1:0]            ar_addr_q;
    logic                             drop;
    logic                             ar_valid_q;
    logic                             r_ready_q;
    logic                             push;
    logic                             pop;
    logic                             full;
    logic                             empty;
    logic [CW-1:0]                    count;
    logic [CW-1:0]                    free_slots;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] head;

    assign free_slots = CW'(FIFO_DEPTH) - count;
    assign pop        = instr_ready && !empty;
    assign push       = state == DATA && amba_master.r_valid && !drop && (!full || pop);

    assign instr_valid = !empty;
    assign instr_addr  = empty ? '0 : head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
    assign instr_data  = empty ? '0 : head[DATA_WIDTH-1:0];

    assign amba_master.ar_valid = ar_valid_q;
    assign amba_master.ar_addr  = ar_addr_q;
    assign amba_master.r_ready  = r_ready_q;
    assign amba_master.aw_valid = 1'b0;
    assign amba_master.aw_addr  = '0;
    assign amba_master.w_valid  = 1'b0;
    assign amba_master.w_data   = '0;
    assign amba_master.b_ready  = 1'b1;

    fetch_fifo #(
        .WIDTH (ADDR_WIDTH + DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({req_addr, amba_master.r_data}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // request FSM: address phase held stable until accepted, redirects mid-flight drop the response
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_addr   <= RESET_ADDR;
            pend_addr  <= '0;
            drop       <= 1'b0;
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            r_ready_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_valid)
                        req_addr <= redirect_addr;
                    if (fetch_en && free_slots != '0) begin
                        state      <= ADDR;
                        ar_valid_q <= 1'b1;
                        ar_addr_q  <= redirect_valid ? redirect_addr : req_addr;
                    end
                end
                ADDR: begin
                    if (redirect_valid) begin
                        drop      <= 1'b1;
                        pend_addr <= redirect_addr;
                    end
                    if (amba_master.ar_ready) begin
                        state      <= DATA;
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                    end
                end
                DATA: begin
                    if (amba_master.r_valid) begin
                        state     <= IDLE;
                        r_ready_q <= 1'b0;
                        drop      <= 1'b0;
                        req_addr  <= redirect_valid ? redirect_addr : drop ? pend_addr : req_addr + 1'b1;
                    end else if (redirect_valid) begin
                        drop      <= 1'b1;
                        pend_addr <= redirect_addr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // saturating counters for accepted responses and full-FIFO stall cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (push && perf_fetch_cnt != '1)
                perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
            if (fetch_en && state == IDLE && free_slots == '0 && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_axi4_lite_fetch_master.sv
// tb_axi4_lite_fetch_master: directed vector table plus hand sequences against a small AXI4-Lite ROM model
module tb_axi4_lite_fetch_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [9:0]  redirect_addr;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [9:0]  instr_addr;
    logic        instr_ready;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    AXI_BUS #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus();

    axi4_lite_fetch_master dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .instr_valid    (instr_valid),
        .instr_data     (instr_data),
        .instr_addr     (instr_addr),
        .instr_ready    (instr_ready),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .amba_master    (bus)
    );

    // ROM slave: data equals word address, ar_ready after ar_delay wait cycles
    int          ar_delay = 0;
    int          wcnt;
    logic        rv;
    logic [31:0] rd;
    assign bus.ar_ready = bus.ar_valid && (wcnt >= ar_delay);
    assign bus.r_valid  = rv;
    assign bus.r_data   = rd;

    always @(posedge clk) begin
        if (rst) begin
            wcnt <= 0;
            rv   <= 1'b0;
            rd   <= '0;
        end else begin
            wcnt <= (bus.ar_valid && !bus.ar_ready) ? wcnt + 1 : 0;
            if (bus.ar_valid && bus.ar_ready) begin
                rv <= 1'b1;
                rd <= 32'(bus.ar_addr);
            end else if (rv && bus.r_ready)
                rv <= 1'b0;
        end
    end

    // bus and consumer observers
    int          ar_cnt;
    int          r_cnt;
    logic [9:0]  last_ar;
    logic [41:0] pops[$];

    always @(posedge clk) begin
        if (rst) begin
            ar_cnt <= 0;
            r_cnt  <= 0;
        end else begin
            if (bus.ar_valid && bus.ar_ready) begin
                ar_cnt  <= ar_cnt + 1;
                last_ar <= bus.ar_addr;
            end
            if (bus.r_valid && bus.r_ready)
                r_cnt <= r_cnt + 1;
            if (instr_valid && instr_ready)
                pops.push_back({instr_addr, instr_data});
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        fetch_en       = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        ar_delay       = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pops.delete();
    endtask

    typedef struct packed {
        logic        fe;
        logic        ir;
        logic        arv;
        logic [9:0]  aa;
        logic        rr;
        logic        iv;
        logic [9:0]  ia;
        logic [31:0] id;
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 1, 0, 0, 1, 0, 0, 0};
        tbl[3]  = '{1, 1, 0, 0, 0, 1, 0, 0};
        tbl[4]  = '{1, 1, 1, 1, 0, 0, 0, 0};
        tbl[5]  = '{1, 1, 0, 0, 1, 0, 0, 0};
        tbl[6]  = '{1, 1, 0, 0, 0, 1, 1, 1};
        tbl[7]  = '{1, 1, 1, 2, 0, 0, 0, 0};
        tbl[8]  = '{1, 1, 0, 0, 1, 0, 0, 0};
        tbl[9]  = '{1, 1, 0, 0, 0, 1, 2, 2};
        tbl[10] = '{1, 1, 1, 3, 0, 0, 0, 0};
        tbl[11] = '{1, 1, 0, 0, 1, 0, 0, 0};
        tbl[12] = '{0, 1, 0, 0, 0, 1, 3, 3};

        do_reset();
        chk("rst_instr_data", instr_data, 0);
        chk("rst_instr_addr", instr_addr, 0);

        for (int i = 0; i < 13; i++) begin
            fetch_en    = tbl[i].fe;
            instr_ready = tbl[i].ir;
            chk($sformatf("v%0d_ar_valid", i), bus.ar_valid, tbl[i].arv);
            chk($sformatf("v%0d_r_ready", i), bus.r_ready, tbl[i].rr);
            chk($sformatf("v%0d_instr_valid", i), instr_valid, tbl[i].iv);
            if (tbl[i].arv)
                chk($sformatf("v%0d_ar_addr", i), bus.ar_addr, tbl[i].aa);
            if (tbl[i].iv) begin
                chk($sformatf("v%0d_instr_addr", i), instr_addr, tbl[i].ia);
                chk($sformatf("v%0d_instr_data", i), instr_data, tbl[i].id);
            end
            @(posedge clk);
            #1;
        end

        // FIFO fills with consumer stalled, then resumes at address 4
        do_reset();
        fetch_en = 1'b1;
        for (int i = 0; i < 60 && r_cnt < 4; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (10) @(posedge clk);
        #1;
        chk("full_ar_cnt", ar_cnt, 4);
        chk("full_ar_valid", bus.ar_valid, 0);
        chk("full_instr_valid", instr_valid, 1);
        chk("full_head_addr", instr_addr, 0);
        instr_ready = 1'b1;
        for (int i = 0; i < 40 && pops.size() < 5; i++) begin
            @(posedge clk);
            #1;
        end
        chk("resume_timeout", pops.size() >= 5, 1);
        chk("resume_ar_addr", last_ar, 10'h004);
        for (int i = 0; i < 5 && i < pops.size(); i++)
            chk($sformatf("resume_pop%0d", i), pops[i], {10'(i), 32'(i)});

        // redirect while the address phase is stalled
        do_reset();
        ar_delay    = 2;
        instr_ready = 1'b1;
        fetch_en    = 1'b1;
        for (int i = 0; i < 20 && !bus.ar_valid; i++) begin
            @(posedge clk);
            #1;
        end
        chk("redir_arv_timeout", bus.ar_valid, 1);
        redirect_valid = 1'b1;
        redirect_addr  = 10'h100;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        chk("redir_hold1", {bus.ar_valid, bus.ar_addr}, {1'b1, 10'h000});
        @(posedge clk);
        #1;
        chk("redir_hold2", {bus.ar_valid, bus.ar_addr}, {1'b1, 10'h000});
        for (int i = 0; i < 40 && pops.size() < 1; i++) begin
            @(posedge clk);
            #1;
        end
        chk("redir_pop_timeout", pops.size() >= 1, 1);
        chk("redir_second_ar", ar_cnt >= 2, 1);
        if (pops.size() >= 1)
            chk("redir_first_word", pops[0], {10'h100, 32'h100});

        // address wrap from the top of the space
        do_reset();
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 10'h3FE;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        fetch_en       = 1'b1;
        for (int i = 0; i < 40 && pops.size() < 3; i++) begin
            @(posedge clk);
            #1;
        end
        chk("wrap_timeout", pops.size() >= 3, 1);
        if (pops.size() >= 3) begin
            chk("wrap0", pops[0], {10'h3FE, 32'h3FE});
            chk("wrap1", pops[1], {10'h3FF, 32'h3FF});
            chk("wrap2", pops[2], {10'h000, 32'h000});
        end

        // reset in the middle of a data phase
        do_reset();
        fetch_en = 1'b1;
        begin
            int n = 0;
            for (int i = 0; i < 40 && n < 2; i++) begin
                @(posedge clk);
                #1;
                if (bus.r_ready)
                    n++;
            end
        end
        chk("mid_r_valid", {bus.r_ready, bus.r_valid, instr_valid}, 3'b111);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_ar_valid", bus.ar_valid, 0);
        chk("mid_rst_r_ready", bus.r_ready, 0);
        chk("mid_rst_instr_valid", instr_valid, 0);
        chk("mid_rst_instr_data", instr_data, 0);
        chk("mid_rst_instr_addr", instr_addr, 0);
        for (int i = 0; i < 20 && !bus.ar_valid; i++) begin
            @(posedge clk);
            #1;
        end
        chk("mid_rst_refetch", {bus.ar_valid, bus.ar_addr}, {1'b1, 10'h000});

`ifdef FETCH_PERF_CNT_EN
        // 5 accepted fetches and 3 stall cycles with the FIFO full
        do_reset();
        fetch_en = 1'b1;
        for (int i = 0; i < 60 && r_cnt < 4; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        fetch_en    = 1'b0;
        instr_ready = 1'b1;
        @(posedge clk);
        #1;
        instr_ready = 1'b0;
        fetch_en    = 1'b1;
        for (int i = 0; i < 20 && r_cnt < 5; i++) begin
            @(posedge clk);
            #1;
        end
        fetch_en = 1'b0;
        @(posedge clk);
        #1;
        chk("perf_fetch_cnt", perf_fetch_cnt, 5);
        chk("perf_stall_cnt", perf_stall_cnt, 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi4_lite_fetch_master.md
# axi4_lite_fetch_master

Sequential instruction-fetch AXI4-Lite read master that drives the read channels of the AXI4-Lite ROM slave over the `AXI_BUS` interface. It generates word addresses and keeps one read outstanding. Returned words go into a small prefetch FIFO, which the core consumes through a valid/ready port. A redirect input restarts fetching at a new address and flushes stale data.

## Interface
- `DATA_WIDTH`, 32: instruction/data word width; equals the bus data width.
- `ADDR_WIDTH`, 10: word-address width; address space is 2^ADDR_WIDTH words.
- `FIFO_DEPTH`, 4: prefetch FIFO entries; power of two, ≥2.
- `RESET_ADDR`, 0: first fetch address after reset.
- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fetch_en`  in  1  permits issuing new read requests.
- `redirect_valid`  in  1  one-cycle pulse; restart fetch at `redirect_addr`.
- `redirect_addr`  in  ADDR_WIDTH  new fetch word address.
- `instr_valid`  out  1  FIFO head valid.
- `instr_data`  out  DATA_WIDTH  FIFO head word.
- `instr_addr`  out  ADDR_WIDTH  word address of the FIFO head.
- `instr_ready`  in  1  consumer pops the head when high together with `instr_valid`.
- `amba_master`  AXI_BUS.Master  —  uses `ar_valid`, `ar_ready`, `ar_addr`, `r_valid`, `r_ready`, `r_data`; write channels tied inactive (valids 0, `b_ready` 1).

## Operation
- States in `fetch_pkg::state_t`: IDLE, ADDR, DATA.
- **IDLE**: `ar_valid`=0, `r_ready`=0. Move to ADDR when `fetch_en` is high and `free_slots > 0`.
  - `free_slots` = FIFO_DEPTH − occupancy. Only one read is ever outstanding, so one free slot is enough.
- **ADDR**: `ar_valid`=1 and `ar_addr`=`req_addr`, both registered.
  - On `ar_ready`, move to DATA.
  - `ar_valid` and `ar_addr` stay stable until accepted, even across redirect or `fetch_en` falling.
- **DATA**: `r_ready`=1. On `r_valid`:
  - If `drop`=0, push {`req_addr`, `r_data`} into the FIFO.
  - `req_addr` ← `req_addr`+1, wrapping modulo 2^ADDR_WIDTH; 2^ADDR_WIDTH−1 wraps to 0.
  - Clear `drop` and return to IDLE.
- **Redirect**:
  - The FIFO is flushed the same cycle; `instr_valid`=0 on the next cycle.
  - In IDLE: `req_addr` ← `redirect_addr`.
  - In ADDR or DATA: set `drop`=1 and latch `redirect_addr` into `pend_addr`. When the response completes, `req_addr` ← `pend_addr` instead of incrementing.
  - A second redirect while `drop`=1 overwrites `pend_addr`; the last one wins.
- **Pop/push collisions**:
  - Pop and push in the same cycle on a full FIFO: both allowed; occupancy unchanged.
  - Redirect in the same cycle as pop or push: flush wins and the pushed word is discarded.
- **Reset** (any state, including mid-transaction):
  - state=IDLE, `req_addr`=RESET_ADDR, `drop`=0, FIFO empty.
  - `ar_valid`=0, `r_ready`=0, `instr_valid`=0, `instr_data`=0, `instr_addr`=0.

## Timing
- `fetch_en` rises in cycle t with the FIFO not full: `ar_valid`=1 in t+1.
- `ar_ready` high in t+1: `r_ready`=1 from t+2.
- `r_valid` in cycle u: `instr_valid`=1 in u+1.
- Back-to-back throughput with a zero-wait slave is one word per 3 cycles (IDLE→ADDR→DATA).
- `instr_data` and `instr_addr` come straight from FIFO registers, with no combinational path from the bus.

## Configuration
- `FETCH_PERF_CNT_EN` defined: adds two 32-bit outputs, both reset to 0, saturating at 2^32−1.
  - `perf_fetch_cnt`: counts accepted (non-dropped) responses.
  - `perf_stall_cnt`: counts cycles with `fetch_en`=1, state=IDLE and the FIFO full.
- Undefined: neither port nor counter exists; all other behaviour is identical.

## Structure
- Package `fetch_pkg` holds:
  - `state_t` enum (IDLE, ADDR, DATA);
  - `fifo_entry_t` struct {addr, data}, parameterised via package localparams that default to 32 and 10.
- Sub-module `fetch_fifo`: synchronous FIFO with push, pop, flush, full, empty and count outputs; flush has priority over push.

## Test plan
- Reset, then `fetch_en`=1, zero-wait slave returning data = address, `instr_ready`=1 → words 0,1,2,3 appear in order with `instr_addr` 0..3, one every 3 cycles.
- `instr_ready`=0 with FIFO_DEPTH=4 → exactly 4 reads issued, then `ar_valid` stays 0. Raise `instr_ready` → fetching resumes at address 4.
- Redirect to 0x100 in the cycle `ar_valid`=1 with the slave delaying `ar_ready` 2 cycles → `ar_addr` holds the old address until accepted, that response is dropped, next `ar_addr`=0x100, and the first consumer word has `instr_addr`=0x100.
- Start at address 0x3FE (ADDR_WIDTH=10) → fetch order 0x3FE, 0x3FF, 0x000.
- Assert `rst` while in DATA with `r_valid` pending → next cycle `ar_valid`=0, `r_ready`=0, `instr_valid`=0; the next fetch uses RESET_ADDR.
- With `FETCH_PERF_CNT_EN`, 5 fetches and 3 full-FIFO stall cycles → `perf_fetch_cnt`=5, `perf_stall_cnt`=3.
